// File: rtl/hazard_sched_if.sv
// ID-stage hazard scheduler bus: decoded operands in, pipeline control and perf counters out.
interface hazard_sched_if #(
  parameter int NREG_W = 6,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [NREG_W-1:0] id_rs;
  logic [NREG_W-1:0] id_rt;
  logic [NREG_W-1:0] id_rd;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_reg_write;
  logic              ex_redirect;
  logic              pc_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              issue;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_reg_write, ex_redirect,
    input  pc_write, ifid_flush, idex_bubble, issue, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_reg_write, ex_redirect,
    output pc_write, ifid_flush, idex_bubble, issue, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_sched.sv
// Issue scheduler: shift-register scoreboard of in-flight writers, RAW stall and redirect flush,
// plus saturating stall/flush counters.
module hazard_sched_match #(
  parameter int NREG_W = 6
) (
  input  logic              vld,
  input  logic [NREG_W-1:0] rd,
  input  logic [NREG_W-1:0] rs,
  input  logic [NREG_W-1:0] rt,
  output logic              hit_rs,
  output logic              hit_rt
);
  assign hit_rs = vld && (rd == rs);
  assign hit_rt = vld && (rd == rt);
endmodule

module hazard_sched #(
  parameter int NREG_W = 6,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  hazard_sched_if.slave bus
);
  logic [DEPTH-1:0]             vld_pipe;
  logic [DEPTH-1:0][NREG_W-1:0] rd_pipe;
  logic [DEPTH-1:0]             hit_rs, hit_rt;
  logic                         hazard, redirect, stall;
  logic                         ent0_vld;
  logic [CNT_W-1:0]             stall_q, flush_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    hazard_sched_match #(.NREG_W(NREG_W)) u_match (
      .vld    (vld_pipe[i]),
      .rd     (rd_pipe[i]),
      .rs     (bus.id_rs),
      .rt     (bus.id_rt),
      .hit_rs (hit_rs[i]),
      .hit_rt (hit_rt[i])
    );
  end

  // No forwarding and no regfile bypass: every tracked stage up to WB blocks readers.
  assign hazard   = bus.id_valid && ((bus.id_use_rs && |hit_rs) || (bus.id_use_rt && |hit_rt));
  assign redirect = bus.ex_redirect;
  assign stall    = hazard && !redirect;
  assign ent0_vld = !redirect && !hazard && bus.id_valid && bus.id_reg_write;

  always_comb begin
    bus.pc_write    = 1'b0;
    bus.ifid_flush  = 1'b1;
    bus.idex_bubble = 1'b1;
    bus.issue       = 1'b0;
    if (rst_n) begin
      if (redirect) begin
        bus.pc_write    = 1'b1;
        bus.ifid_flush  = 1'b1;
        bus.idex_bubble = 1'b1;
      end else if (hazard) begin
        bus.ifid_flush  = 1'b0;
      end else begin
        bus.pc_write    = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = !bus.id_valid;
        bus.issue       = bus.id_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rd_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[DEPTH-2:0], ent0_vld};
      rd_pipe  <= {rd_pipe[DEPTH-2:0], bus.id_rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != {CNT_W{1'b1}}))    stall_q <= stall_q + 1'b1;
      if (redirect && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;
endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: reset, RAW stalls, masking, redirect priority, counter saturation.
module tb_hazard_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  always #5 clk = ~clk;

  hazard_sched_if #(.NREG_W(6), .CNT_W(16)) bus ();
  hazard_sched_if #(.NREG_W(6), .CNT_W(2))  bus_s ();

  hazard_sched #(.NREG_W(6), .DEPTH(3), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  hazard_sched #(.NREG_W(6), .DEPTH(3), .CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  // ctl = {pc_write, ifid_flush, idex_bubble, issue}
  wire [3:0] ctl   = {bus.pc_write, bus.ifid_flush, bus.idex_bubble, bus.issue};
  wire [3:0] ctl_s = {bus_s.pc_write, bus_s.ifid_flush, bus_s.idex_bubble, bus_s.issue};

  localparam logic [3:0] C_ISSUE = 4'b1001;
  localparam logic [3:0] C_STALL = 4'b0010;
  localparam logic [3:0] C_REDIR = 4'b1110;
  localparam logic [3:0] C_RST   = 4'b0110;

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input int rs, input int rt, input int rd,
                       input logic urs, input logic urt, input logic rw);
    bus.id_valid = v; bus.id_rs = 6'(rs); bus.id_rt = 6'(rt); bus.id_rd = 6'(rd);
    bus.id_use_rs = urs; bus.id_use_rt = urt; bus.id_reg_write = rw;
  endtask

  task automatic drive_s(input logic v, input int rs, input int rd, input logic urs, input logic rw);
    bus_s.id_valid = v; bus_s.id_rs = 6'(rs); bus_s.id_rt = 6'd0; bus_s.id_rd = 6'(rd);
    bus_s.id_use_rs = urs; bus_s.id_use_rt = 1'b0; bus_s.id_reg_write = rw;
  endtask

  task automatic drain();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) next_cyc();
  endtask

  task automatic test_reset();
    drive(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1);
    bus.ex_redirect = 1'b1;
    #2;
    n_chk++; if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_ctl got %b want %b", ctl, C_RST); end
    n_chk++; if (bus.stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", bus.stall_count); end
    n_chk++; if (bus.flush_count !== 16'd0) begin n_fail++; $display("FAIL reset_flush got %0d want 0", bus.flush_count); end
    next_cyc();
    n_chk++; if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_hold_ctl got %b want %b", ctl, C_RST); end
    bus.ex_redirect = 1'b0;
    drive(1'b1, 1, 2, 9, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl !== C_ISSUE) begin n_fail++; $display("FAIL reset_release_issue got %b want %b", ctl, C_ISSUE); end
    next_cyc();
    drain();
  endtask

  task automatic test_raw_back_to_back();
    drive(1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if (ctl !== C_ISSUE) begin n_fail++; $display("FAIL raw_producer got %b want %b", ctl, C_ISSUE); end
    next_cyc();
    drive(1'b1, 3, 0, 10, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_chk++; if (ctl !== C_STALL) begin n_fail++; $display("FAIL raw_stall_c%0d got %b want %b", c, ctl, C_STALL); end
      next_cyc();
      exp_stall++;
    end
    @(negedge clk);
    n_chk++; if (ctl !== C_ISSUE) begin n_fail++; $display("FAIL raw_issue_c4 got %b want %b", ctl, C_ISSUE); end
    n_chk++; if (bus.stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL raw_stall_count got %0d want %0d", bus.stall_count, exp_stall); end
    next_cyc();
    drain();
  endtask

  task automatic test_independent();
    drive(1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b1);
    next_cyc();
    drive(1'b1, 2, 1, 4, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_chk++; if (ctl !== C_ISSUE) begin n_fail++; $display("FAIL indep_issue_c%0d got %b want %b", c, ctl, C_ISSUE); end
      next_cyc();
    end
    n_chk++; if (bus.stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL indep_stall_count got %0d want %0d", bus.stall_count, exp_stall); end
    drain();
  endtask

  task automatic test_masking();
    drive(1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b0);
    next_cyc();
    drive(1'b1, 3, 0, 4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++; if (ctl !== C_ISSUE) begin n_fail++; $display("FAIL mask_no_regwrite got %b want %b", ctl, C_ISSUE); end
    next_cyc();
    drain();
    drive(1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b1);
    next_cyc();
    drive(1'b1, 5, 3, 4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++; if (ctl !== C_ISSUE) begin n_fail++; $display("FAIL mask_use_rt_off got %b want %b", ctl, C_ISSUE); end
    next_cyc();
    drain();
    drive(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    next_cyc();
    drive(1'b1, 0, 7, 5, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_chk++; if (ctl !== C_STALL) begin n_fail++; $display("FAIL mask_x0_stall_c%0d got %b want %b", c, ctl, C_STALL); end
      next_cyc();
      exp_stall++;
    end
    @(negedge clk);
    n_chk++; if (ctl !== C_ISSUE) begin n_fail++; $display("FAIL mask_x0_issue got %b want %b", ctl, C_ISSUE); end
    n_chk++; if (bus.stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL mask_stall_count got %0d want %0d", bus.stall_count, exp_stall); end
    next_cyc();
    drain();
  endtask

  task automatic test_redirect_stall();
    drive(1'b1, 0, 0, 4, 1'b0, 1'b0, 1'b1);
    next_cyc();
    drive(1'b1, 4, 0, 8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++; if (ctl !== C_STALL) begin n_fail++; $display("FAIL redir_stall1 got %b want %b", ctl, C_STALL); end
    next_cyc();
    exp_stall++;
    bus.ex_redirect = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl !== C_REDIR) begin n_fail++; $display("FAIL redir_ctl got %b want %b", ctl, C_REDIR); end
    next_cyc();
    exp_flush++;
    bus.ex_redirect = 1'b0;
    drive(1'b1, 6, 0, 9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++; if (ctl !== C_ISSUE) begin n_fail++; $display("FAIL redir_next_issue got %b want %b", ctl, C_ISSUE); end
    n_chk++; if (bus.flush_count !== 16'(exp_flush)) begin n_fail++; $display("FAIL redir_flush_count got %0d want %0d", bus.flush_count, exp_flush); end
    n_chk++; if (bus.stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL redir_stall_count got %0d want %0d", bus.stall_count, exp_stall); end
    next_cyc();
    drain();
  endtask

  task automatic test_saturation();
    drive_s(1'b1, 0, 7, 1'b0, 1'b1);
    next_cyc();
    drive_s(1'b1, 7, 1, 1'b1, 1'b0);
    repeat (3) next_cyc();
    n_chk++; if (bus_s.stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_after3 got %0d want 3", bus_s.stall_count); end
    @(negedge clk);
    n_chk++; if (ctl_s !== C_ISSUE) begin n_fail++; $display("FAIL sat_reader_issue got %b want %b", ctl_s, C_ISSUE); end
    next_cyc();
    drive_s(1'b1, 0, 8, 1'b0, 1'b1);
    next_cyc();
    drive_s(1'b1, 8, 1, 1'b1, 1'b0);
    next_cyc();
    n_chk++; if (bus_s.stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_after4 got %0d want 3", bus_s.stall_count); end
    next_cyc();
    n_chk++; if (bus_s.stall_count !== 2'd3) begin n_fail++; $display("FAIL sat_after5 got %0d want 3", bus_s.stall_count); end
    @(negedge clk);
    n_chk++; if (ctl_s !== C_STALL) begin n_fail++; $display("FAIL sat_still_stalling got %b want %b", ctl_s, C_STALL); end
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (bus_s.stall_count !== 2'd0) begin n_fail++; $display("FAIL sat_async_clear got %0d want 0", bus_s.stall_count); end
    n_chk++; if (ctl_s !== C_RST) begin n_fail++; $display("FAIL sat_rst_ctl got %b want %b", ctl_s, C_RST); end
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ctl_s !== C_ISSUE) begin n_fail++; $display("FAIL sat_post_rst_issue got %b want %b", ctl_s, C_ISSUE); end
    next_cyc();
  endtask

  initial begin
    bus.ex_redirect = 1'b0;
    bus_s.ex_redirect = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    drive_s(1'b0, 0, 0, 1'b0, 1'b0);
    test_reset();
    test_raw_back_to_back();
    test_independent();
    test_masking();
    test_redirect_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/hazard_sched.md
# hazard_sched

Issue scheduler and hazard controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It sits beside the ID stage. It tracks in-flight register writers in a small shift-register scoreboard, stalls IF/ID on read-after-write hazards, and flushes wrong-path instructions when EX resolves a taken branch or jump. It drives the PC write enable, the IF/ID flush, and the ID/EX bubble select. It also keeps saturating stall and flush counters for performance debug.

## Interface
- NREG_W, 6, register-index width (instruction fields rd [27:22], rs [21:16], rt [15:10])
- DEPTH, 3, number of in-flight stages tracked after ID (EX, MEM, WB)
- CNT_W, 16, width of performance counters

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID register holds a real instruction
- id_rs  in  NREG_W  source register rs of the instruction in ID
- id_rt  in  NREG_W  source register rt of the instruction in ID
- id_rd  in  NREG_W  destination register of the instruction in ID
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_reg_write  in  1  instruction's decoded RegWrite
- ex_redirect  in  1  EX resolved a taken BranchN/BranchZ, Jump or JumpM this cycle
- pc_write  out  1  PC and IF/ID register load enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load all-zero control into ID/EX (RegWrite, MemWrite, MemRead, branch, jump bits cleared)
- issue  out  1  instruction in ID advances to EX this cycle
- stall_count  out  CNT_W  cycles lost to RAW stalls, saturating
- flush_count  out  CNT_W  redirect events, saturating

## Operation
- The scoreboard has DEPTH entries {v, rd}. Entry 0 = EX, entry DEPTH-1 = WB.
  - Every clock: entry[i] <= entry[i-1] for i >= 1. Downstream stages never stall.
  - Entry 0 loads the ID-stage writer described under "Issue" below.
- The register file does not bypass, and there is no forwarding. A producer in WB still blocks its readers.
- Register 0 is an ordinary register and is compared like any other.
- match(r) = OR over i of (entry[i].v and entry[i].rd == r).
- hazard = id_valid & ((id_use_rs & match(id_rs)) | (id_use_rt & match(id_rt))).
- Priority, evaluated combinationally each cycle:
  1. Redirect (ex_redirect=1):
     - pc_write=1 (PC takes the target), ifid_flush=1, idex_bubble=1, issue=0.
     - entry0 <= invalid.
     - flush_count += 1.
     - A simultaneous hazard is ignored and not counted.
  2. Stall (hazard=1):
     - pc_write=0, ifid_flush=0, idex_bubble=1, issue=0.
     - entry0 <= invalid.
     - stall_count += 1.
  3. Issue (otherwise):
     - pc_write=1, ifid_flush=0, idex_bubble=!id_valid, issue=id_valid.
     - entry0 <= {id_valid & id_reg_write, id_rd}.
- There is no WAW or WAR check. Issue is in order and writeback is in order.
- Both counters stop at 2^CNT_W-1 and never wrap.

## Timing
- Outputs pc_write, ifid_flush, idex_bubble and issue are combinational from the inputs and the scoreboard. There is no output register.
- Scoreboard and counters update on the rising edge of clk.
- While rst_n=0, the following values are forced regardless of inputs:
  - pc_write=0, ifid_flush=1, idex_bubble=1, issue=0.
  - All entries invalid; stall_count=0, flush_count=0.
- Assertion of rst_n takes effect immediately (asynchronous). Release of rst_n is sampled by the first rising edge of clk.
- Reset in the middle of a stall clears the scoreboard. The first cycle after release issues without stalling.
- RAW latency: a reader that enters ID one cycle behind its producer stalls exactly DEPTH cycles (3). It issues on the 4th cycle.
- A reader that enters ID k cycles behind its producer (1 <= k <= DEPTH) stalls DEPTH-k+1 cycles. For k > DEPTH there is no stall.
- Redirect: the instruction in ID and the instruction being fetched in IF are both discarded in the same cycle. Fetch resumes at the target on the next cycle.

## Test plan
- Reset: hold rst_n=0 with id_valid=1 and ex_redirect=1.
  - Required: pc_write=0, ifid_flush=1, idex_bubble=1, issue=0, both counts 0.
  - Release rst_n: issue=1 on the first cycle.
- RAW back-to-back: producer rd=x3, reg_write=1 issues at cycle 0. At cycle 1, a reader with rs=x3, use_rs=1 enters ID.
  - Required: pc_write=0 and idex_bubble=1 in cycles 1-3, issue=1 in cycle 4.
  - Required: stall_count=3.
- Independent stream: producer writes x3, reader uses x2 and x1 (use_rs=use_rt=1).
  - Required: issue=1 every cycle, stall_count stays 0.
- Hazard masking, each case with the reader at distance 1:
  - Producer with reg_write=0 and rd=x3, reader rs=x3: no stall.
  - Producer writes x3, reader has rt=x3 with use_rt=0: no stall.
  - Producer writes x0, reader rs=x0: 3 stall cycles.
- Redirect during stall: in cycle 2 of a RAW stall, pulse ex_redirect.
  - Required: pc_write=1, ifid_flush=1, issue=0 in that cycle.
  - Required: flush_count=1, stall_count=1 (the redirect cycle is not counted as a stall).
  - Required: next cycle, with a new non-dependent instruction in ID, issue=1.
- Saturation: CNT_W=2, force 5 separate stall cycles.
  - Required: stall_count=3 after the 3rd stall and stays 3.
  - Assert rst_n=0 mid-stall: count returns to 0 immediately.
